// File: rtl/edge_bit_packer.sv
// edge_bit_packer: 1 bit/pixel canny packer, SOF-framed bytes into a FWFT FIFO; define CHECKSUM_EN for an XOR trailer byte
module edge_bit_packer #(
  parameter int H_RES = 172,
  parameter int V_RES = 240,
  parameter logic [7:0] THRESH = 8'd128,
  parameter logic [7:0] SOF_BYTE = 8'hA5,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_de,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_overflow
);
  localparam int N = H_RES * V_RES;
  localparam int PW = $clog2(N + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];
`ifdef CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, PAYLOAD, CKSUM, SOF_PEND} state_t;
  logic [7:0] xr;
`else
  typedef enum logic [0:0] {IDLE, PAYLOAD} state_t;
`endif
  state_t state, state_n;
  logic [PW-1:0] pix_cnt, pix_cnt_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] sh, sh_n, sh_in, push_data;
  logic px, last, push, sof, done_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr, rd, rd_n, cnt_n;
  logic pop, full, wen, drop;
  assign o_busy = state != IDLE;
  always_comb begin
    px = i_data >= THRESH;
    sh_in = {sh[6:0], px};
    last = pix_cnt == PW'(N - 1);
    state_n = state;
    pix_cnt_n = pix_cnt;
    bit_cnt_n = bit_cnt;
    sh_n = sh;
    push = 1'b0;
    sof = 1'b0;
    done_n = 1'b0;
    push_data = sh_in << (3'd7 - bit_cnt);
    case (state)
      IDLE: if (i_de) begin
        push = 1'b1;
        sof = 1'b1;
        push_data = SOF_BYTE;
        sh_n = {7'b0, px};
        bit_cnt_n = 3'd1;
        pix_cnt_n = PW'(1);
        state_n = PAYLOAD;
      end
`ifdef CHECKSUM_EN
      CKSUM: begin
        push = 1'b1;
        push_data = xr;
        done_n = 1'b1;
        sh_n = {7'b0, px};
        bit_cnt_n = 3'd1;
        pix_cnt_n = PW'(1);
        state_n = i_de ? SOF_PEND : IDLE;
      end
      SOF_PEND: begin
        push = 1'b1;
        sof = 1'b1;
        push_data = SOF_BYTE;
        state_n = PAYLOAD;
        if (i_de) begin
          sh_n = sh_in;
          bit_cnt_n = bit_cnt + 3'd1;
          pix_cnt_n = pix_cnt + PW'(1);
        end
      end
`endif
      default: if (i_de) begin
        sh_n = sh_in;
        bit_cnt_n = last ? 3'd0 : bit_cnt + 3'd1;
        pix_cnt_n = last ? '0 : pix_cnt + PW'(1);
        push = bit_cnt == 3'd7 || last;
`ifdef CHECKSUM_EN
        state_n = last ? CKSUM : PAYLOAD;
`else
        state_n = last ? IDLE : PAYLOAD;
        done_n = last;
`endif
      end
    endcase
    pop = o_valid && i_ready;
    full = (wr - rd) == FULL_CNT;
    wen = push && (!full || pop);
    drop = push && !wen;
    rd_n = rd + {{AW{1'b0}}, pop};
    cnt_n = wr + {{AW{1'b0}}, wen} - rd_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pix_cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
      o_frame_done <= 1'b0;
      o_overflow <= 1'b0;
`ifdef CHECKSUM_EN
      xr <= '0;
`endif
    end else begin
      state <= state_n;
      pix_cnt <= pix_cnt_n;
      bit_cnt <= bit_cnt_n;
      sh <= sh_n;
      o_frame_done <= done_n;
      o_overflow <= (sof ? 1'b0 : o_overflow) | drop;
`ifdef CHECKSUM_EN
      xr <= sof ? 8'd0 : (push && state == PAYLOAD) ? xr ^ push_data : xr;
`endif
    end
  end
  always_ff @(posedge clk) if (wen) mem[wr[AW-1:0]] <= push_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr <= '0;
      rd <= '0;
      o_valid <= 1'b0;
      o_data <= '0;
    end else begin
      wr <= wr + {{AW{1'b0}}, wen};
      rd <= rd_n;
      o_valid <= |cnt_n;
      o_data <= (wen && wr[AW-1:0] == rd_n[AW-1:0]) ? push_data : mem[rd_n[AW-1:0]];
    end
  end
endmodule
